// File: rtl/alu_pkg.sv
// Shared constants for the ALU muldiv slot: sequencer state encodings,
// operand widths and the field layout of the muldiv output word.
package alu_pkg;

   localparam int DW = 16;
   localparam int BW = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_ITER = 2'd2;
   localparam logic [1:0] ST_FIX  = 2'd3;

   localparam int REM_W_LSB = 16;
   localparam int QUO_W_LSB = 0;
   localparam int REM_B_LSB = 8;
   localparam int QUO_B_LSB = 0;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it fits.
module div_step
   import alu_pkg::*;
(
   input  logic [DW:0]   rem_i,
   input  logic          bit_i,
   input  logic [DW-1:0] divisor_i,
   output logic [DW:0]   rem_o,
   output logic          q_o
);

   logic [DW+1:0] shifted;
   logic [DW+1:0] diff;

   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {2'b00, divisor_i};
   // A clear top bit means the subtraction did not borrow.
   assign q_o     = ~diff[DW+1];
   assign rem_o   = q_o ? diff[DW:0] : shifted[DW:0];

endmodule

// File: rtl/div_seq.sv
// Multicycle DIV/IDIV sequencer: restoring division at one quotient bit per
// clock, with 8086 divide-error detection and muldiv output layout.
module div_seq
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] x,
   input  logic [15:0] y,
   input  logic        word_op,
   input  logic        signed_op,
   output logic        busy,
   output logic        done,
   output logic        div_err,
   output logic [31:0] out
);

   logic [1:0]    state_q, state_d;
   logic [31:0]   x_q, x_d;
   logic [DW-1:0] y_q, y_d;
   logic          word_q, word_d;
   logic          signed_q, signed_d;
   logic          q_neg_q, q_neg_d;
   logic          r_neg_q, r_neg_d;
   logic [DW:0]   rem_q, rem_d;
   logic [DW-1:0] low_q, low_d;
   logic [3:0]    count_q, count_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [31:0]   out_q, out_d;

   logic          x_neg, y_neg;
   logic [31:0]   mag_x;
   logic [DW-1:0] mag_y, upper, low_init;
   logic [DW:0]   step_rem_in, step_rem_out;
   logic          step_bit, step_q;
   logic [DW-1:0] quo_mag, quo_val, rem_val;
   logic          range_err;
   logic [31:0]   fix_out;

   assign x_neg = signed_q & (word_q ? x_q[31] : x_q[DW-1]);
   assign y_neg = signed_q & (word_q ? y_q[DW-1] : y_q[BW-1]);

   // Byte operands are aligned so the next dividend bit is always low[DW-1].
   always_comb begin
      mag_x = '0;
      mag_y = '0;
      if (word_q) begin
         mag_x = x_neg ? -x_q : x_q;
         mag_y = y_neg ? -y_q : y_q;
      end else begin
         mag_x[DW-1:0] = x_neg ? -x_q[DW-1:0] : x_q[DW-1:0];
         mag_y[BW-1:0] = y_neg ? -y_q[BW-1:0] : y_q[BW-1:0];
      end
   end

   assign upper    = word_q ? mag_x[31:16] : {8'h00, mag_x[DW-1:BW]};
   assign low_init = word_q ? mag_x[DW-1:0] : {mag_x[BW-1:0], 8'h00};

   // LOAD performs the first step so the iteration finishes one cycle earlier.
   assign step_rem_in = (state_q == ST_LOAD) ? {1'b0, upper} : rem_q;
   assign step_bit    = (state_q == ST_LOAD) ? low_init[DW-1] : low_q[DW-1];

   div_step u_step (
      .rem_i     (step_rem_in),
      .bit_i     (step_bit),
      .divisor_i (mag_y),
      .rem_o     (step_rem_out),
      .q_o       (step_q)
   );

   assign quo_mag   = word_q ? low_q : {8'h00, low_q[BW-1:0]};
   assign range_err = signed_q & (word_q ? low_q[DW-1] : low_q[BW-1]);
   assign quo_val   = q_neg_q ? -quo_mag : quo_mag;
   assign rem_val   = r_neg_q ? -rem_q[DW-1:0] : rem_q[DW-1:0];

   always_comb begin
      fix_out = '0;
      if (word_q) begin
         fix_out[REM_W_LSB +: DW] = rem_val;
         fix_out[QUO_W_LSB +: DW] = quo_val;
      end else begin
         fix_out[REM_B_LSB +: BW] = rem_val[BW-1:0];
         fix_out[QUO_B_LSB +: BW] = quo_val[BW-1:0];
      end
   end

   // NOTE: every next-state signal gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      word_d   = word_q;
      signed_d = signed_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      rem_d    = rem_q;
      low_d    = low_q;
      count_d  = count_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      out_d    = out_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               x_d      = x;
               y_d      = y;
               word_d   = word_op;
               signed_d = signed_op;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            q_neg_d = x_neg ^ y_neg;
            r_neg_d = x_neg;
            if ((mag_y == '0) || (upper >= mag_y)) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               rem_d   = step_rem_out;
               low_d   = {low_init[DW-2:0], step_q};
               count_d = word_q ? 4'd15 : 4'd7;
               state_d = ST_ITER;
            end
         end
         ST_ITER: begin
            rem_d   = step_rem_out;
            low_d   = {low_q[DW-2:0], step_q};
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) state_d = ST_FIX;
         end
         default: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            if (range_err) err_d = 1'b1;
            else           out_d = fix_out;
         end
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         word_q   <= 1'b0;
         signed_q <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         rem_q    <= '0;
         low_q    <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         word_q   <= word_d;
         signed_q <= signed_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         rem_q    <= rem_d;
         low_q    <= low_d;
         count_q  <= count_d;
         done_q   <= done_d;
         err_q    <= err_d;
         out_q    <= out_d;
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign div_err = err_q;
   assign out     = out_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: arithmetic reference model, per-cycle
// compare process, directed test-plan cases and randomized operations.
module tb_div_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] x;
   logic [15:0] y;
   logic        word_op;
   logic        signed_op;
   logic        busy;
   logic        done;
   logic        div_err;
   logic [31:0] out;

   typedef struct {
      int          s;
      int          d;
      bit          err;
      logic [31:0] o;
   } op_t;

   op_t         pq[$];
   int          cyc;
   int          n_checks;
   int          n_fail;
   bit          chk_en;
   logic [31:0] out_model;
   int          last_start;
   int          last_done;

   div_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .x         (x),
      .y         (y),
      .word_op   (word_op),
      .signed_op (signed_op),
      .busy      (busy),
      .done      (done),
      .div_err   (div_err),
      .out       (out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Truncating division as the 8086 defines it; latency follows from where the fault is detected.
   function automatic void model(input logic [31:0] xv, input logic [15:0] yv, input bit w,
                                 input bit s, output bit err, output logic [31:0] o,
                                 output int lat);
      longint dv, ds, qq, rr, mag, fit_lim, sgn_lim;
      int     n;
      n = w ? 16 : 8;
      if (s) begin
         dv = w ? longint'($signed(xv)) : longint'($signed(xv[15:0]));
         ds = w ? longint'($signed(yv)) : longint'($signed(yv[7:0]));
      end else begin
         dv = w ? longint'(xv) : longint'(xv[15:0]);
         ds = w ? longint'(yv) : longint'(yv[7:0]);
      end
      fit_lim = longint'(1) <<< n;
      sgn_lim = (longint'(1) <<< (n - 1)) - 1;
      o   = '0;
      err = 1'b0;
      lat = n + 2;
      if (ds == 0) begin
         err = 1'b1;
         lat = 2;
      end else begin
         qq  = dv / ds;
         rr  = dv % ds;
         mag = (qq < 0) ? -qq : qq;
         if (mag >= fit_lim) begin
            err = 1'b1;
            lat = 2;
         end else if (s && (mag > sgn_lim)) begin
            err = 1'b1;
         end else begin
            o = w ? {rr[15:0], qq[15:0]} : {16'h0000, rr[7:0], qq[7:0]};
         end
      end
   endfunction

   // Compare process: checks every output on every cycle against the queued model results.
   always @(negedge clk) begin
      bit exp_busy, exp_done, exp_err;
      if (chk_en && !rst) begin
         exp_busy = 1'b0;
         exp_done = 1'b0;
         exp_err  = 1'b0;
         if (pq.size() > 0) begin
            exp_busy = (cyc > pq[0].s) && (cyc < pq[0].d);
            if (cyc == pq[0].d) begin
               exp_done = 1'b1;
               exp_err  = pq[0].err;
               if (!pq[0].err) out_model = pq[0].o;
            end
         end
         check("busy", {31'b0, busy}, {31'b0, exp_busy});
         check("done", {31'b0, done}, {31'b0, exp_done});
         check("div_err", {31'b0, div_err}, {31'b0, exp_err});
         check("out", out, out_model);
         if (exp_done) void'(pq.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic scramble();
      x         = $urandom;
      y         = 16'($urandom);
      word_op   = 1'($urandom);
      signed_op = 1'($urandom);
   endtask

   task automatic issue(input logic [31:0] xv, input logic [15:0] yv, input bit w, input bit s);
      op_t op;
      int  lat;
      model(xv, yv, w, s, op.err, op.o, lat);
      op.s       = cyc;
      op.d       = cyc + lat;
      last_start = op.s;
      last_done  = op.d;
      pq.push_back(op);
      x          = xv;
      y          = yv;
      word_op    = w;
      signed_op  = s;
      start      = 1'b1;
      step();
      start      = 1'b0;
      scramble();
   endtask

   // Start pulse while the DUT is busy; it must be ignored, so no result is queued.
   task automatic pulse_ignored();
      scramble();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done();
      while (cyc < last_done) step();
   endtask

   task automatic pin(input string name, input logic [31:0] xv, input logic [15:0] yv,
                      input bit w, input bit s, input bit e_err, input logic [31:0] e_out,
                      input int e_lat);
      bit          err;
      logic [31:0] o;
      int          lat;
      model(xv, yv, w, s, err, o, lat);
      check({name, "_err"}, {31'b0, err}, {31'b0, e_err});
      check({name, "_lat"}, lat, e_lat);
      if (!e_err) check({name, "_out"}, o, e_out);
   endtask

   initial begin
      logic [31:0] rx;
      logic [15:0] ry;
      bit          rw, rs;
      n_checks  = 0;
      n_fail    = 0;
      chk_en    = 1'b0;
      out_model = '0;
      cyc       = 0;
      rst       = 1'b1;
      start     = 1'b0;
      x         = '0;
      y         = '0;
      word_op   = 1'b0;
      signed_op = 1'b0;

      pin("pin_uw",  32'h000186A0, 16'h012C, 1'b1, 1'b0, 1'b0, 32'h0064014D, 18);
      pin("pin_ub",  32'h00000064, 16'h0007, 1'b0, 1'b0, 1'b0, 32'h0000020E, 10);
      pin("pin_sw1", 32'hFFFFFFF9, 16'h0002, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFD, 18);
      pin("pin_sw2", 32'h00000007, 16'hFFFE, 1'b1, 1'b1, 1'b0, 32'h0001FFFD, 18);
      pin("pin_dz",  32'h12345678, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h0, 2);
      pin("pin_ovf", 32'h00020000, 16'h0002, 1'b1, 1'b0, 1'b1, 32'h0, 2);
      pin("pin_sb",  32'h0000FF80, 16'h0001, 1'b0, 1'b1, 1'b1, 32'h0, 10);

      repeat (3) step();
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_out", out, 32'd0);
      rst = 1'b0;
      step();
      chk_en = 1'b1;

      issue(32'h000186A0, 16'h012C, 1'b1, 1'b0);
      wait_done();
      check("tp_uw_cycle", cyc - last_start, 32'd18);
      check("tp_uw_out", out, 32'h0064014D);
      step();
      issue(32'h00000064, 16'h0007, 1'b0, 1'b0);
      wait_done();
      check("tp_ub_out", out, 32'h0000020E);
      step();
      issue(32'hFFFFFFF9, 16'h0002, 1'b1, 1'b1);
      wait_done();
      check("tp_sw1_out", out, 32'hFFFFFFFD);
      step();
      issue(32'h00000007, 16'hFFFE, 1'b1, 1'b1);
      wait_done();
      check("tp_sw2_out", out, 32'h0001FFFD);
      step();
      issue(32'hDEADBEEF, 16'h0000, 1'b1, 1'b0);
      wait_done();
      check("tp_dz_err", {31'b0, div_err}, 32'd1);
      check("tp_dz_out_held", out, 32'h0001FFFD);
      step();
      issue(32'h00020000, 16'h0002, 1'b1, 1'b0);
      wait_done();
      step();
      issue(32'h0000FF80, 16'h0001, 1'b0, 1'b1);
      wait_done();
      check("tp_sb_err", {31'b0, div_err}, 32'd1);
      step();

      issue(32'h000186A0, 16'h012C, 1'b1, 1'b0);
      step();
      pulse_ignored();
      wait_done();
      issue(32'h00000064, 16'h0007, 1'b0, 1'b0);
      wait_done();
      issue(32'hFFFFFFF9, 16'h0002, 1'b1, 1'b1);
      wait_done();
      step();

      for (int i = 0; i < 300; i++) begin
         rw = 1'($urandom);
         rs = 1'($urandom);
         rx = $urandom;
         ry = 16'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            rx[31:16] = rx[31:16] >> $urandom_range(1, 16);
            rx[15:8]  = rx[15:8] >> $urandom_range(1, 8);
         end
         if ($urandom_range(0, 15) == 0) ry = '0;
         issue(rx, ry, rw, rs);
         if ($urandom_range(0, 3) == 0) pulse_ignored();
         wait_done();
         repeat ($urandom_range(0, 2)) step();
      end
      wait_done();
      step();

      issue(32'h000186A0, 16'h012C, 1'b1, 1'b0);
      wait_done();
      step();
      issue(32'h00000007, 16'hFFFE, 1'b1, 1'b1);
      while (cyc < last_start + 7) step();
      rst = 1'b1;
      pq.delete();
      out_model = '0;
      #1;
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      check("rst_mid_done", {31'b0, done}, 32'd0);
      check("rst_mid_out", out, 32'd0);
      step();
      rst = 1'b0;
      step();
      issue(32'h00000064, 16'h0007, 1'b0, 1'b0);
      wait_done();
      check("post_rst_out", out, 32'h0000020E);
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
